// File: rtl/fft_out_reorder.sv
// fft_out_reorder: reorders bit-reversed FFT output pairs into natural bin order.
// Pairs from the DIF FFT core are written at bit-reversed addresses into a
// two-bank ping-pong frame buffer. Completed frames stream out one complex
// sample per cycle under a valid/ready handshake.
// Optional macro FFT_REORDER_INDEX_EN adds the out_index port.
// Ports:
//   clk, nrst              clock, async active-low reset
//   start                  frame sync, restarts the input frame count
//   in_valid / in_ready    input pair handshake
//   inReal0/inImag0        pair sample 0
//   inReal1/inImag1        pair sample 1
//   out_valid / out_ready  output sample handshake
//   outReal/outImag        natural-order output sample
//   frame_last             high with bin N-1
//   out_index              bin number of the output sample (macro only)
//   overflow               sticky, a pair arrived while in_ready was low
module fft_out_reorder #(
  parameter int unsigned BW    = 16,
  parameter int unsigned LOG2N = 6
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    inReal0,
  input  logic [BW-1:0]    inImag0,
  input  logic [BW-1:0]    inReal1,
  input  logic [BW-1:0]    inImag1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    outReal,
  output logic [BW-1:0]    outImag,
  output logic             frame_last,
`ifdef FFT_REORDER_INDEX_EN
  output logic [LOG2N-1:0] out_index,
`endif
  output logic             overflow
);

  localparam int unsigned N    = 1 << LOG2N;
  localparam int unsigned HALF = N / 2;
  localparam int unsigned WW   = LOG2N - 1;
  localparam int unsigned DW   = 2 * BW;

  localparam logic [LOG2N-1:0] LAST_BIN  = LOG2N'(N - 1);
  localparam logic [WW-1:0]    LAST_PAIR = WW'(HALF - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [DW-1:0] mem [0:1][0:N-1];

  logic [0:0]       state, state_nx;
  logic             wr_bank, wr_bank_nx;
  logic             rd_bank, rd_bank_nx;
  logic [WW-1:0]    wr_cnt, wr_cnt_nx;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_nx;
  logic [1:0]       full, full_nx;
  logic             out_valid_nx, frame_last_nx, overflow_nx, in_ready_nx;

  logic             wr_en;
  logic [WW-1:0]    pair;
  logic [LOG2N-1:0] wa0, wa1;
  logic             load;
  logic             ld_bank;
  logic [LOG2N-1:0] ld_addr;
  logic [DW-1:0]    ld_data;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Next-state: write counter/banks, read FSM, output load select.
  always_comb begin
    state_nx     = state;
    wr_bank_nx   = wr_bank;
    rd_bank_nx   = rd_bank;
    wr_cnt_nx    = wr_cnt;
    rd_cnt_nx    = rd_cnt;
    full_nx      = full;
    out_valid_nx = out_valid;
    overflow_nx  = overflow;
    load         = 1'b0;
    ld_bank      = rd_bank;
    ld_addr      = '0;

    wr_en = in_valid && in_ready;
    // start restarts the frame; a pair arriving with it is pair 0
    pair  = start ? '0 : wr_cnt;
    wa0   = bitrev({pair, 1'b0});
    wa1   = bitrev({pair, 1'b1});

    if (in_valid && !in_ready) overflow_nx = 1'b1;
    if (start) wr_cnt_nx = '0;
    if (wr_en) begin
      if (pair == LAST_PAIR) begin
        full_nx[wr_bank] = 1'b1;
        wr_bank_nx       = ~wr_bank;
        wr_cnt_nx        = '0;
      end else begin
        wr_cnt_nx = WW'(pair + 1'b1);
      end
    end

    case (state)
      S_IDLE: begin
        if (full[rd_bank]) begin
          load         = 1'b1;
          ld_bank      = rd_bank;
          ld_addr      = '0;
          rd_cnt_nx    = '0;
          out_valid_nx = 1'b1;
          state_nx     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_valid && out_ready) begin
          if (rd_cnt != LAST_BIN) begin
            rd_cnt_nx = LOG2N'(rd_cnt + 1'b1);
            load      = 1'b1;
            ld_bank   = rd_bank;
            ld_addr   = LOG2N'(rd_cnt + 1'b1);
          end else begin
            // frame done: free the bank, chain straight into the other if ready
            full_nx[rd_bank] = 1'b0;
            rd_bank_nx       = ~rd_bank;
            rd_cnt_nx        = '0;
            if (full[~rd_bank]) begin
              load    = 1'b1;
              ld_bank = ~rd_bank;
              ld_addr = '0;
            end else begin
              out_valid_nx = 1'b0;
              state_nx     = S_IDLE;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    ld_data       = mem[ld_bank][ld_addr];
    in_ready_nx   = !full_nx[wr_bank_nx];
    frame_last_nx = out_valid_nx && (rd_cnt_nx == LAST_BIN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      full       <= '0;
      out_valid  <= 1'b0;
      outReal    <= '0;
      outImag    <= '0;
      frame_last <= 1'b0;
      overflow   <= 1'b0;
      in_ready   <= 1'b0;
`ifdef FFT_REORDER_INDEX_EN
      out_index  <= '0;
`endif
    end else begin
      state      <= state_nx;
      wr_bank    <= wr_bank_nx;
      rd_bank    <= rd_bank_nx;
      wr_cnt     <= wr_cnt_nx;
      rd_cnt     <= rd_cnt_nx;
      full       <= full_nx;
      out_valid  <= out_valid_nx;
      frame_last <= frame_last_nx;
      overflow   <= overflow_nx;
      in_ready   <= in_ready_nx;
      if (load) begin
        outReal <= ld_data[DW-1:BW];
        outImag <= ld_data[BW-1:0];
`ifdef FFT_REORDER_INDEX_EN
        out_index <= ld_addr;
`endif
      end
    end
  end

  // Frame buffer, unreset; both pair samples land in the write bank together.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wa0] <= {inReal0, inImag0};
      mem[wr_bank][wa1] <= {inReal1, inImag1};
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed self-checking bench for fft_out_reorder (N=64).
module tb_fft_out_reorder;

  localparam int unsigned BW = 16;

  logic          clk, nrst, start, in_valid, in_ready, out_valid, out_ready;
  logic [BW-1:0] inReal0, inImag0, inReal1, inImag1, outReal, outImag;
  logic          frame_last, overflow;
`ifdef FFT_REORDER_INDEX_EN
  logic [5:0]    out_index;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32:0] rx_q[$];
  int          rx_cyc[$];
  logic        stall = 1'b0;
  logic [31:0] held  = '0;

  fft_out_reorder #(.BW(BW), .LOG2N(6)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .inReal0(inReal0), .inImag0(inImag0),
    .inReal1(inReal1), .inImag1(inImag1),
    .out_valid(out_valid), .out_ready(out_ready),
    .outReal(outReal), .outImag(outImag),
    .frame_last(frame_last),
`ifdef FFT_REORDER_INDEX_EN
    .out_index(out_index),
`endif
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] tb_bitrev(input int v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  // Output monitor: logs handshakes and checks data stays put while stalled.
  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'({outReal, outImag}), 64'(held));
      end
      if (out_valid && out_ready) begin
        rx_q.push_back({frame_last, outReal, outImag});
        rx_cyc.push_back(cyc);
      end
      stall = out_valid && !out_ready;
      held  = {outReal, outImag};
    end
  end

  // Drive pairs first..first+count-1 of a frame tagged by base, one per cycle.
  task automatic push_pairs(input logic [15:0] base, input int first, input int count, input bit sync);
    for (int p = first; p < first + count; p++) begin
      in_valid = 1'b1;
      start    = sync && (p == first);
      inReal0  = base + 16'(tb_bitrev(2 * p));
      inReal1  = base + 16'(int'(tb_bitrev(2 * p)) + 32);
      inImag0  = inReal0 ^ 16'h5A00;
      inImag1  = inReal1 ^ 16'h5A00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("rx_count", 64'(rx_q.size()), 64'(n));
  endtask

  task automatic check_rx(input int idx0, input logic [15:0] base, input string tag);
    logic [15:0] re;
    if (rx_q.size() < idx0 + 64) return;
    for (int k = 0; k < 64; k++) begin
      re = base + 16'(k);
      check($sformatf("%s_bin%0d", tag, k), 64'(rx_q[idx0 + k]),
            64'({k == 63, re, re ^ 16'h5A00}));
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  logic [15:0] pat;

  initial begin
    nrst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inReal0 = '0; inImag0 = '0; inReal1 = '0; inImag1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_frame_last", 64'(frame_last), 64'(0));
    check("rst_data", 64'({outReal, outImag}), 64'(0));
    @(negedge clk); #2 nrst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // single frame, latency and natural order
    clear_rx();
    push_pairs(16'h0000, 0, 32, 1'b0);
    check("lat_pre_valid", 64'(out_valid), 64'(0));
    check("lat_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_bin0", 64'(outReal), 64'(0));
    wait_rx(64, 200);
    check_rx(0, 16'h0000, "f1");

    // back-pressure pattern
    clear_rx();
    push_pairs(16'h0100, 0, 32, 1'b0);
    pat = 16'b1001_0110_1001_1001;
    for (int c = 0; c < 400 && rx_q.size() < 64; c++) begin
      out_ready = pat[c % 16];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_rx(64, 50);
    check_rx(0, 16'h0100, "bp");

    // two back-to-back frames, no output gap
    clear_rx();
    push_pairs(16'h0200, 0, 32, 1'b0);
    push_pairs(16'h0300, 0, 32, 1'b0);
    wait_rx(128, 300);
    check_rx(0, 16'h0200, "b2bA");
    check_rx(64, 16'h0300, "b2bB");
    if (rx_cyc.size() >= 128)
      check("b2b_contig", 64'(rx_cyc[127] - rx_cyc[0]), 64'(127));

    // stalled consumer, third frame overflows
    repeat (5) @(posedge clk);
    #1;
    clear_rx();
    out_ready = 1'b0;
    push_pairs(16'h0400, 0, 32, 1'b0);
    check("ovf_ready_f1", 64'(in_ready), 64'(1));
    push_pairs(16'h0500, 0, 32, 1'b0);
    check("ovf_ready_f2", 64'(in_ready), 64'(0));
    check("ovf_pre", 64'(overflow), 64'(0));
    push_pairs(16'h0600, 0, 1, 1'b0);
    check("ovf_set", 64'(overflow), 64'(1));
    push_pairs(16'h0600, 1, 31, 1'b0);
    out_ready = 1'b1;
    wait_rx(128, 300);
    check_rx(0, 16'h0400, "ovfA");
    check_rx(64, 16'h0500, "ovfB");
    repeat (80) @(posedge clk);
    #1;
    check("ovf_no_third", 64'(rx_q.size()), 64'(128));
    check("ovf_idle", 64'(out_valid), 64'(0));
    check("ovf_sticky", 64'(overflow), 64'(1));

    // start discards a partial frame
    clear_rx();
    push_pairs(16'h0700, 0, 10, 1'b0);
    push_pairs(16'h0800, 0, 32, 1'b1);
    wait_rx(64, 200);
    check_rx(0, 16'h0800, "sync");
    repeat (20) @(posedge clk);
    #1;
    check("sync_no_stale", 64'(rx_q.size()), 64'(64));

    // asynchronous reset mid-stream
    clear_rx();
    push_pairs(16'h0900, 0, 32, 1'b0);
    wait_rx(20, 100);
    @(negedge clk); #2 nrst = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_overflow", 64'(overflow), 64'(0));
    check("arst_last", 64'(frame_last), 64'(0));
    @(negedge clk); #3 nrst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_rx();
    check("arst_in_ready", 64'(in_ready), 64'(1));
    push_pairs(16'h0A00, 0, 32, 1'b0);
    wait_rx(64, 200);
    check_rx(0, 16'h0A00, "post");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
